// File: rtl/wb_mem_model_ctl.sv
// Wishbone-classic slave memory with wait states, byte-lane writes, an exit
// mailbox, a cycle/timeout counter and a first-calc-instruction timestamp.
module wb_mem_model_ctl #(
    parameter int                    ADDR_WIDTH     = 30,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = 100001,
    parameter int                    WAIT_CYCLES    = 1,
    parameter string                 INIT_FILE      = "",
    parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR      = 30'h0400_0001,
    parameter logic [DATA_WIDTH-1:0] EXIT_DATA      = 32'h0000_00AD,
    parameter int                    TIMEOUT_CYCLES = 2000000,
    parameter int                    CNT_WIDTH      = 32,
    parameter logic [31:0]           INSN_MATCH     = 32'h0000_2027,
    parameter logic [31:0]           INSN_MASK      = 32'hFE00_707F
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   dat,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic                    we,
    input  logic                    cyc,
    output logic [DATA_WIDTH-1:0]   rdt,
    output logic                    ack,
    input  logic                    insn_valid,
    input  logic [31:0]             insn,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_WIDTH-1:0]    cycle_count,
    output logic [CNT_WIDTH-1:0]    calc_start,
    output logic                    calc_seen
);

    localparam int                   SEL_W     = DATA_WIDTH / 8;
    localparam int                   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                   AW1       = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0]       DEPTH_A   = AW1'(DEPTH);
    localparam logic [3:0]           WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic                  enter_ack;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_wr;
    logic                  exit_hit;
    logic                  timeout_hit;
    logic                  count_run;
    logic                  calc_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Bus handshake: accept, optional wait, one-cycle ack, one idle gap.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        enter_ack    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cyc) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!cyc) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_ACK:   state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign ack = (state == S_ACK);

    // The mailbox word never aliases into the array, even when it lies below DEPTH.
    assign in_range = ({1'b0, adr} < DEPTH_A) && (adr != EXIT_ADDR);
    assign idx      = adr[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;
    assign mem_wr   = enter_ack && we && in_range && !reset;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (sel[i]) begin
                    mem[idx][8*i +: 8] <= dat[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdt <= '0;
        end else if (enter_ack) begin
            rdt <= rd_word;
        end
    end

    // Completion, timeout and the free-running counter; done beats timeout on a tie.
    assign exit_hit    = enter_ack && we && (adr == EXIT_ADDR) && (dat == EXIT_DATA) && (&sel);
    assign timeout_hit = (cycle_count == TO_LAST) && !done && !timeout && !exit_hit;
    assign count_run   = !done && !timeout && !exit_hit && !timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (exit_hit) begin
                done <= 1'b1;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
            if (count_run) begin
                cycle_count <= sat_inc(cycle_count);
            end
        end
    end

    assign calc_hit = insn_valid && ((insn & INSN_MASK) == INSN_MATCH) && !calc_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            calc_seen  <= 1'b0;
            calc_start <= '0;
        end else if (calc_hit) begin
            calc_seen  <= 1'b1;
            calc_start <= cycle_count;
        end
    end

endmodule
